// File: rtl/ldpc_out_pack_pkg.sv
// Shared LDPC constants, FSM encoding and the packed FIFO word used by the
// decoder back end and the output byte packer.
package ldpc_out_pack_pkg;

  localparam int LDPC_K_HALF = 4608;
  localparam int LDPC_K_3Q   = 6912;
  localparam int LDPC_N      = 9216;
  localparam int CNT_W       = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ldpc_state_e;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [7:0] data;
  } pack_word_t;

  localparam int PACK_W = $bits(pack_word_t);

endpackage

// File: rtl/ldpc_byte_fifo.sv
// Circular byte FIFO with wrap-around pointers and registered full/empty flags.
// The head word reads as zero while the FIFO is empty.
module ldpc_byte_fifo #(
  parameter int AW = 3,
  parameter int W  = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          wr, rd;

  always_comb begin
    rd      = pop && !empty_q;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    wr      = push && (!full_q || rd);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (wr) wptr_d = wptr_q + 1'b1;
    if (rd) rptr_d = rptr_q + 1'b1;
    if (wr && !rd) begin
      empty_d = 1'b0;
      full_d  = ((wptr_q + 1'b1) == rptr_q);
    end else if (rd && !wr) begin
      full_d  = 1'b0;
      empty_d = ((rptr_q + 1'b1) == wptr_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= push_data;
  end

  assign pop_data = empty_q ? '0 : mem[rptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign drop     = push && !wr;

endmodule

// File: rtl/ldpc_out_pack.sv
// Packs the decoder's hard-bit stream into MSB-first bytes tagged with
// start/end-of-frame, buffered through a small FIFO with valid/ready output.
module ldpc_out_pack
  import ldpc_out_pack_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int K_HALF  = LDPC_K_HALF,
  parameter int K_3Q    = LDPC_K_3Q
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       data_in,
  input  logic       sync_in,
  input  logic       rate,
  input  logic [4:0] num_iter,
  output logic [7:0] byte_out,
  output logic       byte_sof,
  output logic       byte_eof,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [4:0] frm_iter,
  output logic       frm_err,
  output logic       overflow
);

  localparam logic [CNT_W-1:0] KH = CNT_W'(K_HALF);
  localparam logic [CNT_W-1:0] K3 = CNT_W'(K_3Q);

  ldpc_state_e      state_q, state_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [4:0]       iter_q, iter_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             pend_vld_q, pend_vld_d;
  pack_word_t       pend_q, pend_d;

  logic             start;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] k_cur;
  pack_word_t       head;
  logic             fifo_full, fifo_empty, fifo_drop;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    iter_d     = iter_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    pend_vld_d = 1'b0;
    pend_d     = pend_q;
    start      = sync_in && (state_q != RUN);
    cnt_cur    = cnt_q;
    k_cur      = k_q;

    unique case (state_q)
      IDLE: if (sync_in) state_d = RUN;
      RUN: begin
        if (!sync_in) begin
          state_d = FLUSH;
          if (cnt_q < k_q) err_d = 1'b1;
        end
      end
      FLUSH: begin
        state_d = sync_in ? RUN : IDLE;
        // Partial byte was built MSB-first over a cleared register, so its LSBs are already zero.
        if (cnt_q[2:0] != 3'd0) begin
          pend_vld_d  = 1'b1;
          pend_d.sof  = (cnt_q[CNT_W-1:3] == '0);
          pend_d.eof  = 1'b1;
          pend_d.data = sreg_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A start seen in FLUSH overlaps the old frame's flush; the new frame's
    // first bit lands at byte offset 0 and can never complete a byte here.
    if (start) begin
      k_cur   = rate ? K3 : KH;
      k_d     = k_cur;
      cnt_cur = '0;
      iter_d  = num_iter;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
    end

    if (sync_in) begin
      if (cnt_cur < k_cur) begin
        cnt_d = cnt_cur + 1'b1;
        if (cnt_cur[2:0] == 3'd0) sreg_d = '0;
        sreg_d[3'd7 - cnt_cur[2:0]] = data_in;
        if (cnt_cur[2:0] == 3'd7) begin
          pend_vld_d  = 1'b1;
          pend_d.sof  = (cnt_cur[CNT_W-1:3] == '0);
          pend_d.eof  = (cnt_cur == (k_cur - 1'b1));
          pend_d.data = {sreg_q[7:1], data_in};
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (fifo_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      iter_q     <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      iter_q     <= iter_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end

  ldpc_byte_fifo #(
    .AW (FIFO_AW),
    .W  (PACK_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (pend_vld_q),
    .push_data (pend_q),
    .pop       (byte_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign byte_out   = head.data;
  assign byte_sof   = head.sof;
  assign byte_eof   = head.eof;
  assign byte_valid = !fifo_empty;
  assign frm_iter   = iter_q;
  assign frm_err    = err_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ldpc_out_pack.sv
// Directed/randomised bench for ldpc_out_pack against a frame-level byte model.
module tb_ldpc_out_pack;

  logic       clk = 1'b0;
  logic       reset_n, data_in, sync_in, rate, byte_ready;
  logic [4:0] num_iter;
  logic [7:0] byte_out;
  logic       byte_sof, byte_eof, byte_valid;
  logic [4:0] frm_iter;
  logic       frm_err, overflow;

  int n_assert = 0;
  int n_fail   = 0;

  bit         tx_bits[$];
  logic [9:0] exp_q[$];
  logic [9:0] rx_q[$];

  logic       hold_q = 1'b0;
  logic [9:0] hold_v = '0;

  ldpc_out_pack #(.FIFO_AW(3), .K_HALF(4608), .K_3Q(6912)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .sync_in    (sync_in),
    .rate       (rate),
    .num_iter   (num_iter),
    .byte_out   (byte_out),
    .byte_sof   (byte_sof),
    .byte_eof   (byte_eof),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .frm_iter   (frm_iter),
    .frm_err    (frm_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Collects transfers and checks the head stays put while stalled.
  always @(negedge clk) begin
    if (reset_n && hold_q && byte_valid)
      chk("hold", {22'd0, byte_sof, byte_eof, byte_out}, {22'd0, hold_v});
    hold_q <= reset_n && byte_valid && !byte_ready;
    hold_v <= {byte_sof, byte_eof, byte_out};
    if (reset_n && byte_valid && byte_ready) rx_q.push_back({byte_sof, byte_eof, byte_out});
  end

  task automatic clr();
    exp_q.delete();
    rx_q.delete();
  endtask

  // Expected bytes from the frame rules: first K bits kept, MSB-first, zero padded.
  task automatic model(input int k);
    int n, nb;
    logic [7:0] v;
    logic sof, eof;
    n  = (tx_bits.size() < k) ? tx_bits.size() : k;
    nb = (n + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      v = '0;
      for (int j = 0; j < 8; j++)
        if (8 * b + j < n) v[7 - j] = tx_bits[8 * b + j];
      sof = (b == 0);
      eof = (b == nb - 1) && ((n == k) || (n % 8 != 0));
      exp_q.push_back({sof, eof, v});
    end
  endtask

  task automatic send(input bit r, input logic [4:0] it, input int n, input int mode,
                      input bit lat, input int st_s, input int st_l, input int rst_at);
    logic [7:0] pat;
    logic [7:0] fb;
    bit b;
    pat = 8'hA5;
    tx_bits.delete();
    rate     = r;
    num_iter = it;
    for (int i = 0; i < n; i++) begin
      if (i == st_s) byte_ready = 1'b0;
      if (i == st_s + st_l) byte_ready = 1'b1;
      if (i == rst_at) begin
        chk("pre_rst_valid", {31'd0, byte_valid}, 32'd1);
        sync_in = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, byte_valid}, 32'd0);
        chk("rst_byte", {24'd0, byte_out}, 32'd0);
        chk("rst_iter", {27'd0, frm_iter}, 32'd0);
        chk("rst_err", {30'd0, frm_err, overflow}, 32'd0);
        repeat (3) begin
          @(posedge clk); #1;
          chk("rst_hold_valid", {31'd0, byte_valid}, 32'd0);
        end
        reset_n    = 1'b1;
        byte_ready = 1'b1;
        @(posedge clk); #1;
        return;
      end
      b = (mode == 1) ? pat[7 - (i % 8)] : bit'($urandom_range(0, 1));
      tx_bits.push_back(b);
      data_in = b;
      sync_in = 1'b1;
      @(posedge clk); #1;
      if (i == 0) begin
        rate     = 1'($urandom_range(0, 1));
        num_iter = 5'($urandom_range(0, 31));
      end
      if (lat && i == 7) chk("lat_edge0_valid", {31'd0, byte_valid}, 32'd0);
      if (lat && i == 8) begin
        for (int j = 0; j < 8; j++) fb[7 - j] = tx_bits[j];
        chk("lat_edge1_valid", {31'd0, byte_valid}, 32'd1);
        chk("lat_first_byte", {23'd0, byte_sof, byte_out}, {23'd0, 1'b1, fb});
      end
    end
    sync_in    = 1'b0;
    data_in    = 1'b0;
    byte_ready = 1'b1;
  endtask

  task automatic drain(input string tag);
    int quiet, cyc;
    quiet = 0;
    cyc   = 0;
    while (quiet < 6 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (byte_valid) quiet = 0;
      else quiet++;
    end
    chk({tag, "_drain"}, 32'(cyc < 4000), 32'd1);
  endtask

  task automatic check_frame(input string tag, input bit err, input bit ovf, input logic [4:0] it);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_byte"}, {22'd0, rx_q[i]}, {22'd0, exp_q[i]});
      if (rx_q[i] !== exp_q[i]) break;
    end
    chk({tag, "_err"}, {31'd0, frm_err}, {31'd0, err});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ovf});
    chk({tag, "_iter"}, {27'd0, frm_iter}, {27'd0, it});
  endtask

  task automatic check_gap(input string tag);
    int d, m, bad;
    d   = exp_q.size() - rx_q.size();
    m   = 0;
    bad = 0;
    while (m < rx_q.size() && m < exp_q.size() && rx_q[m] === exp_q[m]) m++;
    chk({tag, "_dropped"}, 32'(d > 0), 32'd1);
    chk({tag, "_held8"}, 32'(m >= 8), 32'd1);
    if (d > 0) begin
      for (int i = m; i < rx_q.size(); i++)
        if (rx_q[i] !== exp_q[i + d]) bad++;
    end
    chk({tag, "_tail"}, bad, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'd1);
    chk({tag, "_err"}, {31'd0, frm_err}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; sync_in = 1'b0; data_in = 1'b0;
    rate = 1'b0; num_iter = '0; byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, byte_valid}, 32'd0);
    chk("reset_byte", {24'd0, byte_out}, 32'd0);
    chk("reset_iter", {27'd0, frm_iter}, 32'd0);
    chk("reset_flags", {30'd0, frm_err, overflow}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    clr(); send(1'b0, 5'd3, 4608, 0, 1'b1, -1, 0, -1); model(4608);
    drain("half"); check_frame("half", 1'b0, 1'b0, 5'd3);

    clr(); send(1'b1, 5'd7, 6912, 1, 1'b0, -1, 0, -1); model(6912);
    drain("a5"); check_frame("a5", 1'b0, 1'b0, 5'd7);

    clr(); send(1'b0, 5'd2, 4605, 0, 1'b0, -1, 0, -1); model(4608);
    drain("short"); check_frame("short", 1'b1, 1'b0, 5'd2);

    clr(); send(1'b0, 5'd4, 4608, 0, 1'b0, 0, 80, -1); model(4608);
    drain("stall"); check_gap("stall");

    clr(); send(1'b0, 5'd1, 2000, 0, 1'b0, 960, 5000, 1000);
    clr(); send(1'b0, 5'd9, 4608, 0, 1'b0, -1, 0, -1); model(4608);
    drain("postrst"); check_frame("postrst", 1'b0, 1'b0, 5'd9);

    clr(); send(1'b0, 5'd5, 4608, 0, 1'b0, -1, 0, -1); model(4608);
    @(posedge clk); #1;
    send(1'b0, 5'd6, 4608, 0, 1'b0, -1, 0, -1); model(4608);
    drain("b2b"); check_frame("b2b", 1'b0, 1'b0, 5'd6);

    clr(); send(1'b1, 5'd12, 6915, 0, 1'b0, -1, 0, -1); model(6912);
    drain("long"); check_frame("long", 1'b1, 1'b0, 5'd12);

    clr(); send(1'b1, 5'd31, 800, 0, 1'b0, -1, 0, -1); model(6912);
    drain("trunc8"); check_frame("trunc8", 1'b1, 1'b0, 5'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
